// File: rtl/loader_pkg.sv
// Shared state encoding and default sizing for the UART-to-SRAM frame loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LD_IDLE,
    S_LD_WAIT_HI,
    S_LD_WAIT_LO,
    S_LD_WRITE,
    S_LD_DONE
  } loader_state_e;

  // One 320x240 RGB frame packed as 16-bit words, and a one-second idle limit at 50 MHz.
  localparam logic [17:0] FRAME_WORDS            = 18'd115200;
  localparam logic [25:0] DEFAULT_TIMEOUT_CYCLES = 26'd50000000;

endpackage

// File: rtl/uart_sram_loader.sv
// Packs pairs of received UART bytes (big-endian) into 16-bit words and writes them to SRAM.
// Optional inter-byte idle timeout enabled with `define SRAM_LOADER_TIMEOUT_EN.
module uart_sram_loader
  import loader_pkg::*;
#(
  parameter logic [17:0] START_ADDR     = 18'd0,
  parameter logic [17:0] NUM_WORDS      = FRAME_WORDS,
  parameter logic [25:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  Byte_data,
  input  logic        Byte_valid,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Busy,
  output logic        Done,
  output logic        Timeout
);

  loader_state_e state, next_state;
  logic [7:0]  high_byte;
  logic [17:0] word_count;
  logic        last_word;
  logic        idle_expired;

  assign last_word = (word_count == NUM_WORDS - 18'd1);

`ifdef SRAM_LOADER_TIMEOUT_EN
  logic [25:0] idle_count;
  logic        waiting;
  logic        timeout_flag;

  assign waiting      = (state == S_LD_WAIT_HI) || (state == S_LD_WAIT_LO);
  assign idle_expired = waiting && !Byte_valid && (idle_count == TIMEOUT_CYCLES - 26'd1);
  assign Timeout      = timeout_flag;

  // Counter only runs while waiting for a byte; any other state leaves it cleared for the next wait.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      idle_count   <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (!waiting || Byte_valid) idle_count <= '0;
      else                        idle_count <= idle_count + 26'd1;
      if (state == S_LD_IDLE && Start) timeout_flag <= 1'b0;
      else if (idle_expired)           timeout_flag <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign idle_expired       = 1'b0;
  assign Timeout            = 1'b0;
`endif

  assign SRAM_we_n = (state != S_LD_WRITE);
  assign Busy      = (state != S_LD_IDLE);
  assign Done      = (state == S_LD_DONE);

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) state <= S_LD_IDLE;
    else       state <= next_state;
  end

  // A byte arriving during the write cycle already starts the next pair, so back-to-back bytes are never lost.
  always_comb begin
    next_state = state;
    unique case (state)
      S_LD_IDLE:    if (Start) next_state = S_LD_WAIT_HI;
      S_LD_WAIT_HI: begin
        if (Byte_valid)        next_state = S_LD_WAIT_LO;
        else if (idle_expired) next_state = S_LD_DONE;
      end
      S_LD_WAIT_LO: begin
        if (Byte_valid)        next_state = S_LD_WRITE;
        else if (idle_expired) next_state = S_LD_DONE;
      end
      S_LD_WRITE: begin
        if (last_word)       next_state = S_LD_DONE;
        else if (Byte_valid) next_state = S_LD_WAIT_LO;
        else                 next_state = S_LD_WAIT_HI;
      end
      S_LD_DONE:    next_state = S_LD_IDLE;
      default:      next_state = S_LD_IDLE;
    endcase
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      high_byte       <= '0;
      word_count      <= '0;
    end else begin
      case (state)
        S_LD_IDLE: if (Start) begin
          SRAM_address <= START_ADDR;
          word_count   <= '0;
        end
        S_LD_WAIT_HI: if (Byte_valid) high_byte <= Byte_data;
        S_LD_WAIT_LO: if (Byte_valid) SRAM_write_data <= {high_byte, Byte_data};
        S_LD_WRITE: begin
          SRAM_address <= SRAM_address + 18'd1;
          word_count   <= word_count + 18'd1;
          if (!last_word && Byte_valid) high_byte <= Byte_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sram_loader.sv
// Scoreboard bench for uart_sram_loader: two instances (base 0 and base 3FFFE) share one byte stream.
// Timeout expectations follow `define SRAM_LOADER_TIMEOUT_EN.
module tb_uart_sram_loader;

  logic        Clock_50;
  logic        Reset;
  logic        Start;
  logic [7:0]  Byte_data;
  logic        Byte_valid;

  logic [17:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        we_n0, we_n1, busy0, busy1, done0, done1, timeout0, timeout1;

  int checks = 0;
  int errors = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  logic prev_we_n0, prev_we_n1, prev_done0, prev_done1;
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];

  uart_sram_loader #(.START_ADDR(18'd0), .NUM_WORDS(18'd4), .TIMEOUT_CYCLES(26'd100)) dut0 (
    .Clock_50(Clock_50), .Reset(Reset), .Start(Start), .Byte_data(Byte_data), .Byte_valid(Byte_valid),
    .SRAM_address(addr0), .SRAM_write_data(wdata0), .SRAM_we_n(we_n0),
    .Busy(busy0), .Done(done0), .Timeout(timeout0)
  );

  uart_sram_loader #(.START_ADDR(18'h3FFFE), .NUM_WORDS(18'd4), .TIMEOUT_CYCLES(26'd100)) dut1 (
    .Clock_50(Clock_50), .Reset(Reset), .Start(Start), .Byte_data(Byte_data), .Byte_valid(Byte_valid),
    .SRAM_address(addr1), .SRAM_write_data(wdata1), .SRAM_we_n(we_n1),
    .Busy(busy1), .Done(done1), .Timeout(timeout1)
  );

  initial Clock_50 = 1'b0;
  always #10 Clock_50 = ~Clock_50;

  task automatic check_output(input string name, input logic [33:0] actual, input logic [33:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Holds inputs for exactly one clock, then returns one time unit after the edge.
  task automatic apply_stimulus(input logic s, input logic v, input logic [7:0] d);
    Start = s; Byte_valid = v; Byte_data = d;
    @(posedge Clock_50); #1;
    Start = 1'b0; Byte_valid = 1'b0; Byte_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    @(posedge Clock_50); #1;
    @(posedge Clock_50); #1;
    Reset = 1'b0;
  endtask

  // Word index i lands at base+i on each instance; dut1 wraps past 3FFFF.
  task automatic push_word(input int idx, input logic [15:0] word);
    logic [17:0] a0, a1;
    a0 = 18'(idx);
    a1 = 18'h3FFFE + 18'(idx);
    exp_q0.push_back({a0, word});
    exp_q1.push_back({a1, word});
  endtask

  // Monitor: every write strobe pops the scoreboard; strobes must be a single cycle wide.
  always @(negedge Clock_50) begin
    if (Reset) begin
      prev_we_n0 <= 1'b1; prev_we_n1 <= 1'b1;
      prev_done0 <= 1'b0; prev_done1 <= 1'b0;
    end else begin
      if (!we_n0) begin
        if (!prev_we_n0) check_output("dut0_we_width", 34'd2, 34'd1);
        if (exp_q0.size() == 0) check_output("dut0_unexpected_write", {addr0, wdata0}, 34'h0);
        else check_output("dut0_write", {addr0, wdata0}, exp_q0.pop_front());
      end
      if (!we_n1) begin
        if (!prev_we_n1) check_output("dut1_we_width", 34'd2, 34'd1);
        if (exp_q1.size() == 0) check_output("dut1_unexpected_write", {addr1, wdata1}, 34'h0);
        else check_output("dut1_write", {addr1, wdata1}, exp_q1.pop_front());
      end
      if (done0) begin
        if (prev_done0) check_output("dut0_done_width", 34'd2, 34'd1);
        done_cnt0++;
      end
      if (done1) begin
        if (prev_done1) check_output("dut1_done_width", 34'd2, 34'd1);
        done_cnt1++;
      end
      prev_we_n0 <= we_n0; prev_we_n1 <= we_n1;
      prev_done0 <= done0; prev_done1 <= done1;
    end
  end

  logic [7:0]  t1_bytes [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  logic [15:0] t1_words [4] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
  logic [7:0]  t2_bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [15:0] t2_words [4] = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};

  initial begin
    Reset = 1'b1; Start = 1'b0; Byte_valid = 1'b0; Byte_data = 8'h00;
    #1;
    check_output("reset_addr0", 34'(addr0), 34'h0);
    check_output("reset_we_n0", 34'(we_n0), 34'h1);
    apply_reset();
    check_output("idle_busy0", 34'(busy0), 34'h0);
    check_output("idle_done0", 34'(done0), 34'h0);
    check_output("idle_timeout0", 34'(timeout0), 34'h0);

    // Basic load with a gap between every byte
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("t1_busy0", 34'(busy0), 34'h1);
    check_output("t1_start_addr1", 34'(addr1), 34'h3FFFE);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b1, t1_bytes[2*i]);
      idle(1);
      push_word(i, t1_words[i]);
      apply_stimulus(1'b0, 1'b1, t1_bytes[2*i+1]);
      idle(1);
    end
    idle(2);
    check_output("t1_end_addr0", 34'(addr0), 34'h4);
    check_output("t1_end_addr1", 34'(addr1), 34'h2);
    check_output("t1_done_cnt0", 34'(done_cnt0), 34'h1);
    check_output("t1_done_cnt1", 34'(done_cnt1), 34'h1);
    check_output("t1_busy0", 34'(busy0), 34'h0);

    // Bytes on consecutive cycles, including the write cycles
    apply_stimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) push_word(i / 2, t2_words[i / 2]);
      apply_stimulus(1'b0, 1'b1, t2_bytes[i]);
    end
    idle(3);
    check_output("t2_end_addr0", 34'(addr0), 34'h4);
    check_output("t2_done_cnt0", 34'(done_cnt0), 34'h2);
    check_output("t2_q0_empty", 34'(exp_q0.size()), 34'h0);

    // Ignored bytes in idle/done and ignored Start while busy
    apply_stimulus(1'b0, 1'b1, 8'hFF);
    apply_stimulus(1'b0, 1'b1, 8'hFE);
    check_output("t3_idle_busy0", 34'(busy0), 34'h0);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h21);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    push_word(0, 16'h2122);
    apply_stimulus(1'b0, 1'b1, 8'h22);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("t3_mid_addr0", 34'(addr0), 34'h1);
    apply_stimulus(1'b0, 1'b1, 8'h23);
    push_word(1, 16'h2324);
    apply_stimulus(1'b0, 1'b1, 8'h24);
    idle(1);
    apply_stimulus(1'b0, 1'b1, 8'h25);
    push_word(2, 16'h2526);
    apply_stimulus(1'b0, 1'b1, 8'h26);
    idle(1);
    apply_stimulus(1'b0, 1'b1, 8'h27);
    push_word(3, 16'h2728);
    apply_stimulus(1'b0, 1'b1, 8'h28);
    apply_stimulus(1'b0, 1'b1, 8'hEE);
    apply_stimulus(1'b0, 1'b1, 8'hEF);
    apply_stimulus(1'b0, 1'b1, 8'hF0);
    idle(2);
    check_output("t3_end_addr0", 34'(addr0), 34'h4);
    check_output("t3_end_addr1", 34'(addr1), 34'h2);
    check_output("t3_done_cnt0", 34'(done_cnt0), 34'h3);
    check_output("t3_busy0", 34'(busy0), 34'h0);

    // Reset in the middle of a pair, then a fresh load
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h31);
    push_word(0, 16'h3132);
    apply_stimulus(1'b0, 1'b1, 8'h32);
    apply_stimulus(1'b0, 1'b1, 8'h33);
    Reset = 1'b1;
    #1;
    check_output("t4_rst_addr0", 34'(addr0), 34'h0);
    check_output("t4_rst_addr1", 34'(addr1), 34'h0);
    check_output("t4_rst_wdata0", 34'(wdata0), 34'h0);
    check_output("t4_rst_we_n0", 34'(we_n0), 34'h1);
    check_output("t4_rst_busy0", 34'(busy0), 34'h0);
    check_output("t4_rst_done0", 34'(done0), 34'h0);
    check_output("t4_rst_timeout0", 34'(timeout0), 34'h0);
    @(posedge Clock_50); #1;
    Reset = 1'b0;
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'hAA);
    push_word(0, 16'hAABB);
    apply_stimulus(1'b0, 1'b1, 8'hBB);
    idle(1);
    check_output("t4_busy0", 34'(busy0), 34'h1);
    check_output("t4_addr0", 34'(addr0), 34'h1);
    check_output("t4_q0_empty", 34'(exp_q0.size()), 34'h0);
    apply_reset();

    // One byte then silence
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h5A);
`ifdef SRAM_LOADER_TIMEOUT_EN
    idle(99);
    check_output("t5_pre_timeout0", 34'(timeout0), 34'h0);
    check_output("t5_pre_busy0", 34'(busy0), 34'h1);
    idle(1);
    check_output("t5_timeout0", 34'(timeout0), 34'h1);
    check_output("t5_done0", 34'(done0), 34'h1);
    idle(1);
    check_output("t5_idle_busy0", 34'(busy0), 34'h0);
    check_output("t5_held_timeout0", 34'(timeout0), 34'h1);
    check_output("t5_done_cnt0", 34'(done_cnt0), 34'h4);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("t5_restart_timeout0", 34'(timeout0), 34'h0);
`else
    idle(200);
    check_output("t5_busy0", 34'(busy0), 34'h1);
    check_output("t5_timeout0", 34'(timeout0), 34'h0);
    check_output("t5_done_cnt0", 34'(done_cnt0), 34'h3);
`endif
    check_output("t5_addr0", 34'(addr0), 34'h0);
    apply_reset();
    idle(2);
    check_output("end_q0_empty", 34'(exp_q0.size()), 34'h0);
    check_output("end_q1_empty", 34'(exp_q1.size()), 34'h0);
    check_output("end_done_match", 34'(done_cnt1), 34'(done_cnt0));

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_sram_loader.md
UART_SRAM_LOADER -- requirements
Module: uart_sram_loader

Interface
REQ-001 SHALL provide parameter START_ADDR, default 18'd0, first SRAM word address written.
REQ-002 SHALL provide parameter NUM_WORDS, default 18'd115200, number of 16-bit words per load (one 320x240 RGB frame).
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 26'd50000000, maximum idle cycles between bytes (used only under REQ-026).
REQ-004 SHALL have port Clock_50  input  1  sole clock, rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Start  input  1  single-cycle load request.
REQ-007 SHALL have port Byte_data  input  8  received UART byte.
REQ-008 SHALL have port Byte_valid  input  1  single-cycle strobe qualifying Byte_data.
REQ-009 SHALL have port SRAM_address  output  18  word address to SRAM controller.
REQ-010 SHALL have port SRAM_write_data  output  16  word to SRAM controller.
REQ-011 SHALL have port SRAM_we_n  output  1  active-low write enable.
REQ-012 SHALL have ports Busy, Done, Timeout  output  1 each  status.

Function
REQ-013 SHALL implement states S_LD_IDLE, S_LD_WAIT_HI, S_LD_WAIT_LO, S_LD_WRITE, S_LD_DONE.
REQ-014 In S_LD_IDLE, Start=1 SHALL load SRAM_address=START_ADDR, clear word count and Timeout, and go to S_LD_WAIT_HI; Byte_valid SHALL be ignored.
REQ-015 In S_LD_WAIT_HI, Byte_valid SHALL latch Byte_data as high byte and go to S_LD_WAIT_LO.
REQ-016 In S_LD_WAIT_LO, Byte_valid SHALL register SRAM_write_data={high byte, Byte_data}, drive SRAM_we_n=0 next cycle, and go to S_LD_WRITE.
REQ-017 SRAM_we_n SHALL be low for exactly one cycle per word, with SRAM_address and SRAM_write_data stable throughout that cycle.
REQ-018 In S_LD_WRITE, SHALL set SRAM_we_n=1, increment SRAM_address by 1 (modulo 2^18), and increment word count.
REQ-019 From S_LD_WRITE, when word count equals NUM_WORDS-1, SHALL go to S_LD_DONE; otherwise to S_LD_WAIT_HI.
REQ-020 Byte_valid asserted in S_LD_WRITE (not final word) SHALL be accepted as next high byte, transition to S_LD_WAIT_LO; no byte is dropped.
REQ-021 S_LD_DONE SHALL assert Done for exactly one cycle and return to S_LD_IDLE; bytes arriving in S_LD_DONE are ignored.
REQ-022 Busy SHALL be 1 in every state except S_LD_IDLE; Start while Busy SHALL be ignored.
REQ-023 Byte order SHALL be big-endian: first byte of each pair to bits [15:8].

Reset
REQ-024 Reset=1 SHALL immediately force state S_LD_IDLE, SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, Busy=0, Done=0, Timeout=0, word count=0.
REQ-025 Reset mid-load SHALL abort without completing a pending write; any partial pair is discarded.

Configuration
REQ-026 With SRAM_LOADER_TIMEOUT_EN defined, an idle counter SHALL clear on entry to S_LD_WAIT_HI and on each Byte_valid; reaching TIMEOUT_CYCLES-1 in S_LD_WAIT_HI or S_LD_WAIT_LO SHALL discard any partial pair, set Timeout=1 (held until next accepted Start or Reset), and go to S_LD_DONE.
REQ-027 Without SRAM_LOADER_TIMEOUT_EN, no idle counter SHALL exist, waits are unbounded, and Timeout SHALL be tied 0.

Structure
REQ-028 The state enum and default constants (frame word count 115200, timeout 50000000) SHALL reside in shared package loader_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; UART reception is external.

Verification
REQ-030 Reset, Start, NUM_WORDS=4, bytes 01 02 03 04 05 06 07 08 -> writes 0102@0, 0304@1, 0506@2, 0708@3, each with we_n low one cycle; Done pulses once; SRAM_address ends at 4.
REQ-031 Byte_valid on consecutive cycles including the S_LD_WRITE cycle -> no byte lost, words still correctly paired.
REQ-032 START_ADDR=18'h3FFFE, NUM_WORDS=4 -> writes at 3FFFE, 3FFFF, 00000, 00001.
REQ-033 Start pulsed mid-load and Byte_valid in S_LD_IDLE -> ignored, no extra writes, word count unchanged.
REQ-034 Reset asserted after 3 bytes -> outputs at reset values same cycle; new Start plus 2 bytes AA BB -> AABB written at START_ADDR.
REQ-035 With SRAM_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100, one byte then silence -> after 100 idle cycles Timeout=1, Done pulses, no write; without macro -> Busy stays 1, Timeout stays 0.
